alu_ex_stage: RTL and testbench
===============================

Name: alu_ex_stage

Overview:
Execute-stage pipeline wrapper that sits directly upstream of the 32-bit ALU (4-bit opcode, A/B operands, combinational result). It accepts decoded instructions from decode over a valid/ready handshake and registers them (ID/EX). It resolves RAW hazards by forwarding, drives the ALU operands and opcode, and captures the ALU result into an EX/WB register for writeback. Two-stage pipeline with full backpressure.

Parameters:
DATA_W, 32, operand/result width (must match the ALU)
REG_W, 5, register index width
IMM_W, 16, immediate width, sign-extended to DATA_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage can accept (combinational)
in_opcode  in  4  ALU opcode
in_rs  in  REG_W  source A index
in_rs_val  in  DATA_W  register-file value of rs
in_rt  in  REG_W  source B index
in_rt_val  in  DATA_W  register-file value of rt
in_imm  in  IMM_W  immediate
in_use_imm  in  1  B = sign-extended imm instead of rt
in_rd  in  REG_W  destination index
in_wen  in  1  instruction writes rd
alu_a  out  DATA_W  to ALU A
alu_b  out  DATA_W  to ALU B
alu_opcode  out  4  to ALU opcode
alu_result  in  DATA_W  from ALU result
out_valid  out  1  EX/WB holds a result
out_ready  in  1  writeback accepts
out_result  out  DATA_W  registered ALU result
out_rd  out  REG_W  destination index
out_wen  out  1  write enable

Behaviour:
- Reset (rst=1 at clk edge): s1_valid=0, out_valid=0, out_result=0, out_rd=0, out_wen=0, ret_valid=0, all ID/EX fields=0. in_ready=1 on the first cycle after reset. Reset mid-operation drops all in-flight instructions; nothing is emitted.
- Stage 1 (ID/EX): captures all in_* fields when in_valid && in_ready.
- advance = s1_valid && (!out_valid || out_ready). in_ready = !s1_valid || advance (pass-through when full and draining).
- Stage 2 (EX/WB): on advance, out_result<=alu_result, out_rd<=s1_rd, out_wen<=s1_wen, out_valid<=1. If out_valid && out_ready && !advance, out_valid<=0. If out_valid && !out_ready, EX/WB holds.
- Latency: accept at edge N -> out_valid=1 after edge N+1 when unstalled. Throughput is 1 instruction/cycle.
- Retire register: on out_valid && out_ready, ret_valid<=out_wen, ret_rd<=out_rd, ret_val<=out_result. It covers the one-cycle register-file write gap.
- Forwarding for operand A, using s1_rs, in priority order:
  1. EX/WB result if out_valid && out_wen && out_rd==s1_rs && s1_rs!=0.
  2. Otherwise ret_val if ret_valid && ret_rd==s1_rs && s1_rs!=0.
  3. Otherwise s1_rs_val.
- Forwarding for operand B uses the same priority with s1_rt. If s1_use_imm, alu_b = sign-extended s1_imm and no forwarding is applied.
- Register 0 never forwards. A rs/rt of 0 always uses the supplied value.
- alu_opcode = s1_opcode, driven combinationally from ID/EX. alu_a/alu_b are combinational from ID/EX plus the forwarding muxes. When s1_valid=0, the ALU outputs are don't-care.
- Simultaneous out handshake and advance: EX/WB reloads with the new result; ret updates from the old EX/WB contents in the same edge.
- Opcode is passed through unchecked; all 16 codes are legal.

Test Plan:
- Reset, then in_valid with opcode=0000, rs_val=1, rt_val=1, rd=3, wen=1, out_ready=1 -> out_valid=1 two edges after reset release+accept, out_result=00000002, out_rd=3; in_ready=1 throughout.
- Back-to-back: ADD r3=1+1, then SUB rs=3 (stale rs_val=0), rt_val=1 -> alu_a forwarded=00000002, out_result=00000001.
- Retire forward: r5=00000003 retires; next instruction reads rs=5 with stale value 0 one cycle later -> alu_a=00000003 from ret. rs=0 with in_rs_val=00000007 and a pending rd=0 write -> alu_a=00000007.
- Immediate: opcode=1110, use_imm=1, imm=FFFF -> alu_b=FFFFFFFF (sign-extended), rt forwarding ignored. opcode=0000, imm=0005, rs_val=00000001 -> out_result=00000006.
- Backpressure: out_ready=0 with two instructions issued -> out_valid holds the first result stable, s1 fills, in_ready=0. Raise out_ready -> results emerge in order, one per cycle, none lost or duplicated.
- Reset mid-flight: assert rst with s1 and EX/WB full -> next cycle out_valid=0, out_result=0, ret_valid=0, in_ready=1, and no forwarding from pre-reset data.

Source files
------------

// File: rtl/alu_ex_stage.sv
// ID/EX + EX/WB wrapper around a combinational 32-bit ALU.
// Forwards from EX/WB and a one-entry retire register to resolve RAW hazards.
module alu_ex_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned IMM_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_opcode,
    input  logic [REG_W-1:0]  in_rs,
    input  logic [DATA_W-1:0] in_rs_val,
    input  logic [REG_W-1:0]  in_rt,
    input  logic [DATA_W-1:0] in_rt_val,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic              in_use_imm,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              in_wen,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_wen
);

    // ID/EX register
    logic              s1_valid;
    logic [3:0]        s1_opcode;
    logic [REG_W-1:0]  s1_rs;
    logic [DATA_W-1:0] s1_rs_val;
    logic [REG_W-1:0]  s1_rt;
    logic [DATA_W-1:0] s1_rt_val;
    logic [IMM_W-1:0]  s1_imm;
    logic              s1_use_imm;
    logic [REG_W-1:0]  s1_rd;
    logic              s1_wen;

    // Retire register: holds the last written-back result until the RF catches up
    logic              ret_valid;
    logic [REG_W-1:0]  ret_rd;
    logic [DATA_W-1:0] ret_val;

    logic advance;
    logic accept;
    logic out_fire;

    assign advance  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || advance;
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_opcode  <= '0;
            s1_rs      <= '0;
            s1_rs_val  <= '0;
            s1_rt      <= '0;
            s1_rt_val  <= '0;
            s1_imm     <= '0;
            s1_use_imm <= 1'b0;
            s1_rd      <= '0;
            s1_wen     <= 1'b0;
        end else if (accept) begin
            s1_valid   <= 1'b1;
            s1_opcode  <= in_opcode;
            s1_rs      <= in_rs;
            s1_rs_val  <= in_rs_val;
            s1_rt      <= in_rt;
            s1_rt_val  <= in_rt_val;
            s1_imm     <= in_imm;
            s1_use_imm <= in_use_imm;
            s1_rd      <= in_rd;
            s1_wen     <= in_wen;
        end else if (advance) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_rd     <= '0;
            out_wen    <= 1'b0;
        end else if (advance) begin
            out_valid  <= 1'b1;
            out_result <= alu_result;
            out_rd     <= s1_rd;
            out_wen    <= s1_wen;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

    // Captures the outgoing EX/WB contents, even when EX/WB reloads on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            ret_valid <= 1'b0;
            ret_rd    <= '0;
            ret_val   <= '0;
        end else if (out_fire) begin
            ret_valid <= out_wen;
            ret_rd    <= out_rd;
            ret_val   <= out_result;
        end
    end

    logic a_hit_ex, a_hit_ret, b_hit_ex, b_hit_ret;

    assign a_hit_ex  = out_valid && out_wen && (out_rd == s1_rs) && (s1_rs != '0);
    assign a_hit_ret = ret_valid && (ret_rd == s1_rs) && (s1_rs != '0);
    assign b_hit_ex  = out_valid && out_wen && (out_rd == s1_rt) && (s1_rt != '0);
    assign b_hit_ret = ret_valid && (ret_rd == s1_rt) && (s1_rt != '0);

    assign alu_opcode = s1_opcode;

    always_comb begin
        alu_a = s1_rs_val;
        if (a_hit_ex) begin
            alu_a = out_result;
        end else if (a_hit_ret) begin
            alu_a = ret_val;
        end
    end

    always_comb begin
        alu_b = s1_rt_val;
        if (s1_use_imm) begin
            alu_b = {{(DATA_W-IMM_W){s1_imm[IMM_W-1]}}, s1_imm};
        end else if (b_hit_ex) begin
            alu_b = out_result;
        end else if (b_hit_ret) begin
            alu_b = ret_val;
        end
    end

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed bench for alu_ex_stage with a small behavioural ALU in the loop.
module tb_alu_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic [4:0]  in_rs;
    logic [31:0] in_rs_val;
    logic [4:0]  in_rt;
    logic [31:0] in_rt_val;
    logic [15:0] in_imm;
    logic        in_use_imm;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_wen;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // 0 = add, 1 = sub, anything else = xor
    always_comb begin
        unique case (alu_opcode)
            4'h0:    alu_result = alu_a + alu_b;
            4'h1:    alu_result = alu_a - alu_b;
            default: alu_result = alu_a ^ alu_b;
        endcase
    end

    alu_ex_stage #(.DATA_W(32), .REG_W(5), .IMM_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_rs      (in_rs),
        .in_rs_val  (in_rs_val),
        .in_rt      (in_rt),
        .in_rt_val  (in_rt_val),
        .in_imm     (in_imm),
        .in_use_imm (in_use_imm),
        .in_rd      (in_rd),
        .in_wen     (in_wen),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_wen    (out_wen)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [3:0] op, input logic [4:0] rs, input logic [31:0] rsv,
                           input logic [4:0] rt, input logic [31:0] rtv, input logic [15:0] imm,
                           input logic use_imm, input logic [4:0] rd, input logic wen);
        in_valid   = 1'b1;
        in_opcode  = op;
        in_rs      = rs;
        in_rs_val  = rsv;
        in_rt      = rt;
        in_rt_val  = rtv;
        in_imm     = imm;
        in_use_imm = use_imm;
        in_rd      = rd;
        in_wen     = wen;
    endtask

    // Present and clock once; callers only use this while in_ready is known high
    task automatic issue(input logic [3:0] op, input logic [4:0] rs, input logic [31:0] rsv,
                         input logic [4:0] rt, input logic [31:0] rtv, input logic [15:0] imm,
                         input logic use_imm, input logic [4:0] rd, input logic wen);
        present(op, rs, rsv, rt, rtv, imm, use_imm, rd, wen);
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        present(4'h0, 5'd0, 32'd0, 5'd0, 32'd0, 16'h0, 1'b0, 5'd0, 1'b0);
        in_valid  = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_rd", {27'd0, out_rd}, 32'd0);
        check("rst_out_wen", {31'd0, out_wen}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Basic ADD r3 = 1 + 1, one-cycle latency
        present(4'h0, 5'd1, 32'd1, 5'd2, 32'd1, 16'h0, 1'b0, 5'd3, 1'b1);
        check("t1_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        idle();
        check("t1_s1_only_out_valid", {31'd0, out_valid}, 32'd0);
        check("t1_alu_a", alu_a, 32'd1);
        check("t1_alu_b", alu_b, 32'd1);
        check("t1_in_ready_after", {31'd0, in_ready}, 32'd1);
        tick();
        check("t1_out_valid", {31'd0, out_valid}, 32'd1);
        check("t1_out_result", out_result, 32'h2);
        check("t1_out_rd", {27'd0, out_rd}, 32'd3);
        check("t1_out_wen", {31'd0, out_wen}, 32'd1);
        tick();
        check("t1_drained", {31'd0, out_valid}, 32'd0);

        // Back-to-back: SUB reads r3 from EX/WB
        do_reset();
        issue(4'h0, 5'd1, 32'd1, 5'd2, 32'd1, 16'h0, 1'b0, 5'd3, 1'b1);
        issue(4'h1, 5'd3, 32'd0, 5'd4, 32'd1, 16'h0, 1'b0, 5'd6, 1'b1);
        idle();
        check("b2b_alu_a_fwd_ex", alu_a, 32'h2);
        check("b2b_alu_b", alu_b, 32'h1);
        check("b2b_alu_opcode", {28'd0, alu_opcode}, 32'h1);
        check("b2b_first_result", out_result, 32'h2);
        tick();
        check("b2b_sub_result", out_result, 32'h1);
        check("b2b_sub_rd", {27'd0, out_rd}, 32'd6);
        tick();

        // Retire forward: r5 = 3 sits only in the retire register
        issue(4'h0, 5'd1, 32'd1, 5'd2, 32'd2, 16'h0, 1'b0, 5'd5, 1'b1);
        idle();
        tick();
        issue(4'h0, 5'd5, 32'd0, 5'd0, 32'd4, 16'h0, 1'b0, 5'd7, 1'b1);
        idle();
        check("ret_out_empty", {31'd0, out_valid}, 32'd0);
        check("ret_alu_a_fwd", alu_a, 32'h3);
        check("ret_alu_b_r0", alu_b, 32'h4);
        tick();
        check("ret_result", out_result, 32'h7);

        // Register 0 never forwards even with a pending rd=0 write
        issue(4'h0, 5'd1, 32'd9, 5'd2, 32'd9, 16'h0, 1'b0, 5'd0, 1'b1);
        issue(4'h0, 5'd0, 32'd7, 5'd0, 32'd1, 16'h0, 1'b0, 5'd8, 1'b1);
        idle();
        check("r0_pending_rd", {27'd0, out_rd}, 32'd0);
        check("r0_alu_a", alu_a, 32'h7);
        check("r0_alu_b", alu_b, 32'h1);
        tick();
        check("r0_result", out_result, 32'h8);
        tick();

        // A non-writing instruction must not forward
        issue(4'h0, 5'd1, 32'd2, 5'd2, 32'd3, 16'h0, 1'b0, 5'd12, 1'b0);
        issue(4'h0, 5'd12, 32'd1, 5'd0, 32'd1, 16'h0, 1'b0, 5'd13, 1'b1);
        idle();
        check("nowen_alu_a", alu_a, 32'h1);
        tick();
        check("nowen_result", out_result, 32'h2);
        tick();

        // EX/WB beats retire: r9=3 then r9=10, reader sees 10 on both operands
        issue(4'h0, 5'd1, 32'd1, 5'd2, 32'd2, 16'h0, 1'b0, 5'd9, 1'b1);
        issue(4'h0, 5'd1, 32'd4, 5'd2, 32'd6, 16'h0, 1'b0, 5'd9, 1'b1);
        issue(4'h0, 5'd9, 32'd0, 5'd9, 32'd0, 16'h0, 1'b0, 5'd11, 1'b1);
        check("prio_alu_a", alu_a, 32'd10);
        check("prio_alu_b", alu_b, 32'd10);

        // Immediate overrides rt forwarding (r9 is live in the retire register)
        issue(4'he, 5'd0, 32'h10, 5'd9, 32'd0, 16'hffff, 1'b1, 5'd14, 1'b1);
        check("imm_alu_b_sext", alu_b, 32'hffff_ffff);
        check("imm_alu_opcode", {28'd0, alu_opcode}, 32'he);
        check("prio_result", out_result, 32'd20);
        issue(4'h0, 5'd1, 32'd1, 5'd9, 32'd0, 16'h0005, 1'b1, 5'd15, 1'b1);
        idle();
        check("imm_alu_b_pos", alu_b, 32'h5);
        tick();
        check("imm_result", out_result, 32'h6);
        check("imm_rd", {27'd0, out_rd}, 32'd15);
        tick();

        // Backpressure: two in flight, a third waits on in_ready
        out_ready = 1'b0;
        issue(4'h0, 5'd1, 32'd1, 5'd2, 32'd1, 16'h0, 1'b0, 5'd20, 1'b1);
        issue(4'h0, 5'd1, 32'd2, 5'd2, 32'd3, 16'h0, 1'b0, 5'd21, 1'b1);
        present(4'h0, 5'd1, 32'd10, 5'd2, 32'd10, 16'h0, 1'b0, 5'd22, 1'b1);
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        tick();
        check("bp_hold_result", out_result, 32'h2);
        check("bp_hold_rd", {27'd0, out_rd}, 32'd20);
        check("bp_still_blocked", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        idle();
        check("bp_second_result", out_result, 32'h5);
        check("bp_second_rd", {27'd0, out_rd}, 32'd21);
        tick();
        check("bp_third_result", out_result, 32'd20);
        check("bp_third_rd", {27'd0, out_rd}, 32'd22);
        tick();
        check("bp_drained", {31'd0, out_valid}, 32'd0);

        // Reset mid-flight with r25 live in retire and EX/WB
        issue(4'h0, 5'd1, 32'd3, 5'd2, 32'd4, 16'h0, 1'b0, 5'd25, 1'b1);
        idle();
        tick();
        tick();
        out_ready = 1'b0;
        issue(4'h0, 5'd1, 32'd1, 5'd2, 32'd7, 16'h0, 1'b0, 5'd25, 1'b1);
        issue(4'h0, 5'd1, 32'd1, 5'd2, 32'd1, 16'h0, 1'b0, 5'd26, 1'b1);
        check("mid_full_in_ready", {31'd0, in_ready}, 32'd0);
        do_reset();
        out_ready = 1'b1;
        check("mid_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_out_result", out_result, 32'd0);
        check("mid_out_rd", {27'd0, out_rd}, 32'd0);
        check("mid_in_ready", {31'd0, in_ready}, 32'd1);
        issue(4'h0, 5'd25, 32'h55, 5'd25, 32'h66, 16'h0, 1'b0, 5'd27, 1'b1);
        idle();
        check("mid_nothing_emitted", {31'd0, out_valid}, 32'd0);
        check("mid_alu_a_nofwd", alu_a, 32'h55);
        check("mid_alu_b_nofwd", alu_b, 32'h66);
        tick();
        check("mid_result", out_result, 32'hbb);
        check("mid_rd", {27'd0, out_rd}, 32'd27);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
